// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_sequencer
//  Description : Convnet control block. Runs one image load into SRAM group A,
//                then num_layers convolution layers that ping-pong between
//                groups A and B. Owns the write-port multiplexing of both
//                groups so only the active engine reaches its legal
//                destination group.
//  Options     : LAYER_SEQ_WREG_EN - register all sram_* write outputs
//                (one extra cycle of write latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
   parameter int CH_NUM       = 4,
   parameter int ACT_PER_ADDR = 4,
   parameter int BW_PER_ACT   = 12,
   parameter int ADDR_BW      = 6,
   parameter int LAYER_BW     = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   // host handshake
   input  logic                                      enable,
   input  logic [LAYER_BW-1:0]                       num_layers,
   output logic                                      busy,
   // loader handshake
   output logic                                      load_start,
   input  logic                                      load_done,
   // conv engine handshake
   output logic                                      layer_start,
   output logic [LAYER_BW-1:0]                       layer_idx,
   output logic                                      layer_src_b,
   input  logic                                      layer_done,
   output logic                                      valid,
   output logic                                      done,
   // loader write request (group A only)
   input  logic [3:0]                                ld_wen_a,
   input  logic [CH_NUM*ACT_PER_ADDR-1:0]            ld_wordmask_a,
   input  logic [ADDR_BW-1:0]                        ld_waddr_a,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] ld_wdata_a,
   // conv engine write request, group A
   input  logic [3:0]                                cv_wen_a,
   input  logic [CH_NUM*ACT_PER_ADDR-1:0]            cv_wordmask_a,
   input  logic [ADDR_BW-1:0]                        cv_waddr_a,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] cv_wdata_a,
   // conv engine write request, group B
   input  logic [3:0]                                cv_wen_b,
   input  logic [CH_NUM*ACT_PER_ADDR-1:0]            cv_wordmask_b,
   input  logic [ADDR_BW-1:0]                        cv_waddr_b,
   input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] cv_wdata_b,
   // SRAM group A write port
   output logic [3:0]                                sram_wen_a,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]            sram_wordmask_a,
   output logic [ADDR_BW-1:0]                        sram_waddr_a,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata_a,
   // SRAM group B write port
   output logic [3:0]                                sram_wen_b,
   output logic [CH_NUM*ACT_PER_ADDR-1:0]            sram_wordmask_b,
   output logic [ADDR_BW-1:0]                        sram_waddr_b,
   output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata_b
);

   localparam int C_M = CH_NUM * ACT_PER_ADDR;
   localparam int C_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_LSTART = 3'd2;
   localparam logic [2:0] ST_LRUN   = 3'd3;
   localparam logic [2:0] ST_FIN    = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_state_next;
   logic [LAYER_BW-1:0] r_n_layers;
   logic [LAYER_BW-1:0] r_layer_idx;
   logic                r_load_first;
   logic                r_valid;

   // index arithmetic one bit wider so idx+1 never wraps at the top count
   logic [LAYER_BW:0]   w_idx_inc;
   logic                w_more_layers;
   logic                w_start_req;
   logic                w_layer_fin;

   assign w_idx_inc     = {1'b0, r_layer_idx} + {{LAYER_BW{1'b0}}, 1'b1};
   assign w_more_layers = (w_idx_inc < {1'b0, r_n_layers});
   assign w_start_req   = (r_state == ST_IDLE) && enable;
   assign w_layer_fin   = (r_state == ST_LRUN) && layer_done;

   // next-state decode; handshakes outside their owning state are ignored
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (enable) w_state_next = ST_LOAD;
         ST_LOAD:   if (load_done)
                       w_state_next = (r_n_layers == '0) ? ST_FIN : ST_LSTART;
         ST_LSTART: w_state_next = ST_LRUN;
         ST_LRUN:   if (layer_done)
                       w_state_next = w_more_layers ? ST_LSTART : ST_FIN;
         ST_FIN:    w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // layer count captured with the start request, held for the whole run
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              r_n_layers <= '0;
      else if (w_start_req) r_n_layers <= num_layers;
   end

   // layer index restarts per run and advances only between layers
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               r_layer_idx <= '0;
      else if (w_start_req)                  r_layer_idx <= '0;
      else if (w_layer_fin && w_more_layers) r_layer_idx <= w_idx_inc[LAYER_BW-1:0];
   end

   // marks the first LOAD cycle so load_start is a single pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_load_first <= 1'b0;
      else     r_load_first <= w_start_req;
   end

   // per-layer completion pulse, one cycle after the accepted layer_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_valid <= 1'b0;
      else     r_valid <= w_layer_fin;
   end

   assign busy        = (r_state != ST_IDLE);
   assign load_start  = (r_state == ST_LOAD) && r_load_first;
   assign layer_start = (r_state == ST_LSTART);
   assign done        = (r_state == ST_FIN);
   assign valid       = r_valid;
   assign layer_idx   = r_layer_idx;
   assign layer_src_b = r_layer_idx[0];

   // ------------------------------------------------------------------------
   // Write-port multiplexing. Group A takes the loader during LOAD and the
   // conv engine on odd layers; group B takes the conv engine on even layers.
   // The conv write aimed at the current source group is never selected.
   // ------------------------------------------------------------------------
   logic [3:0]         w_wen_a;
   logic [C_M-1:0]     w_mask_a;
   logic [ADDR_BW-1:0] w_addr_a;
   logic [C_W-1:0]     w_data_a;
   logic [3:0]         w_wen_b;
   logic [C_M-1:0]     w_mask_b;
   logic [ADDR_BW-1:0] w_addr_b;
   logic [C_W-1:0]     w_data_b;
   logic               w_in_layer;

   assign w_in_layer = (r_state == ST_LSTART) || (r_state == ST_LRUN);

   // select the owner of each write port from the current state
   always_comb begin
      w_wen_a  = 4'hF;
      w_mask_a = '1;
      w_addr_a = '0;
      w_data_a = '0;
      w_wen_b  = 4'hF;
      w_mask_b = '1;
      w_addr_b = '0;
      w_data_b = '0;
      if (r_state == ST_LOAD) begin
         w_wen_a  = ld_wen_a;
         w_mask_a = ld_wordmask_a;
         w_addr_a = ld_waddr_a;
         w_data_a = ld_wdata_a;
      end else if (w_in_layer && layer_src_b) begin
         w_wen_a  = cv_wen_a;
         w_mask_a = cv_wordmask_a;
         w_addr_a = cv_waddr_a;
         w_data_a = cv_wdata_a;
      end else if (w_in_layer && !layer_src_b) begin
         w_wen_b  = cv_wen_b;
         w_mask_b = cv_wordmask_b;
         w_addr_b = cv_waddr_b;
         w_data_b = cv_wdata_b;
      end
   end

`ifdef LAYER_SEQ_WREG_EN
   // registered write ports: the select used is that of the cycle in which
   // the write was presented, so a phase's last write lands correctly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_wen_a      <= 4'hF;
         sram_wordmask_a <= '1;
         sram_waddr_a    <= '0;
         sram_wdata_a    <= '0;
         sram_wen_b      <= 4'hF;
         sram_wordmask_b <= '1;
         sram_waddr_b    <= '0;
         sram_wdata_b    <= '0;
      end else begin
         sram_wen_a      <= w_wen_a;
         sram_wordmask_a <= w_mask_a;
         sram_waddr_a    <= w_addr_a;
         sram_wdata_a    <= w_data_a;
         sram_wen_b      <= w_wen_b;
         sram_wordmask_b <= w_mask_b;
         sram_waddr_b    <= w_addr_b;
         sram_wdata_b    <= w_data_b;
      end
   end
`else
   // zero-latency write ports
   always_comb begin
      sram_wen_a      = w_wen_a;
      sram_wordmask_a = w_mask_a;
      sram_waddr_a    = w_addr_a;
      sram_wdata_a    = w_data_a;
      sram_wen_b      = w_wen_b;
      sram_wordmask_b = w_mask_b;
      sram_waddr_b    = w_addr_b;
      sram_wdata_b    = w_data_b;
   end
`endif

endmodule
`default_nettype wire
